sr_alu_arb: RTL and testbench
=============================

Name: sr_alu_arb

Overview:
Two-requester arbiter and sequencer that shares one sr_alu instance, e.g. between the main pipeline and a packed-SIMD helper unit. It accepts operations over valid/ready request channels and registers operands and result. It routes each response back to the issuing requester over a valid/ready response channel. It also keeps a sticky saturation flag fed by the ALU ov output, in the style of a vxsat CSR.

Parameters:
PRIO_INIT, 0, requester that holds priority after reset (0 or 1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
reqN_valid  in  1  requester N (N=0,1) presents an operation
reqN_ready  out  1  arbiter accepts requester N's operation this cycle
reqN_srcA  in  32  operand A
reqN_srcB  in  32  operand B
reqN_oper  in  3  ALU opcode, `ALU_* encodings from sr_cpu.svh
rspN_valid  out  1  response for requester N is valid
rspN_ready  in  1  requester N consumes the response
rsp_result  out  32  registered ALU result, shared by both response channels
rsp_zero  out  1  registered ALU zero flag
rsp_ov  out  1  registered saturation flag, masked as described below
ov_sticky  out  1  OR of every rsp_ov captured since reset or the last clear
ov_clr  in  1  synchronous clear of ov_sticky
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, any state): state=IDLE, prio=PRIO_INIT, all rsp/req valid and ready low, rsp_result=0, rsp_zero=0, rsp_ov=0, ov_sticky=0. Any in-flight operation is discarded with no response.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. Only one operation is outstanding at a time.
- IDLE:
  - grant = prio when both requesters are valid; otherwise the single valid requester.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. This is combinational; at most one ready is high per cycle.
  - On handshake, latch srcA, srcB, oper and owner=N. Set prio to the other requester (round-robin). Go to EXEC.
  - With no valid requester, stay in IDLE and leave prio unchanged.
- EXEC (1 cycle):
  - The sr_alu instance is fed only from the latched operand registers, never directly from the req ports.
  - At the clock edge, capture result into rsp_result and zero into rsp_zero.
  - rsp_ov = ALU ov only when the latched oper is `ALU_KSLL8 or `ALU_KSLLI8, else 0. The ALU does not drive ov for other opcodes, so it must never reach the register unmasked.
  - Go to RESP.
- RESP:
  - rsp{owner}_valid=1; the other rspN_valid=0.
  - rsp_result, rsp_zero and rsp_ov stay stable until the handshake.
  - When rsp{owner}_ready is high, go to IDLE. The other channel's ready is ignored.
  - Both reqN_ready stay low during EXEC and RESP.
- Latency: request accepted at edge T; rsp_valid high from cycle T+2. This holds with no backpressure.
- Throughput: at most one operation per 3 cycles. A new request cannot be accepted in the same cycle as a response handshake.
- ov_sticky:
  - Set at the EXEC capture edge when the masked ov is 1.
  - ov_clr clears it on the next edge.
  - If a set and ov_clr land on the same edge, set wins and the flag stays 1.
- Requests that are not accepted need not stay stable. The arbiter samples inputs only on the handshake edge.
- An unknown or unused oper code produces the ALU default (ADD) result with ov=0.

Test Plan:
- Single ADD on req0: srcA=5, srcB=7, oper=`ALU_ADD, rsp0_ready=1. Expected: rsp0_valid exactly 2 cycles after accept, rsp_result=12, rsp_zero=0, rsp_ov=0, rsp1_valid never high.
- Contention after reset with PRIO_INIT=0: both requesters valid at once, req0 ADD 1+1, req1 SUB 9-4. Expected: req0 served first (result 2), then req1 (result 5, on rsp1). A third simultaneous pair is then served req0 first again.
- Saturation on req1: oper=`ALU_KSLL8, srcA=0x4001807F, srcB=1. Expected: rsp_result=0x7F02807F, rsp_ov=1, ov_sticky=1. A following ADD gives rsp_ov=0 with ov_sticky still 1. Asserting ov_clr then gives ov_sticky=0.
- Backpressure: SUB 3-3 on req0 with rsp0_ready held low for 5 cycles. Expected: rsp0_valid held high, rsp_result=0 and rsp_zero=1 stable, req0_ready and req1_ready low, busy=1. Raising rsp1_ready meanwhile has no effect.
- ov_clr collision: ov_clr asserted on the EXEC capture edge of a saturating KSLL8 (srcA=0x0000007F, srcB=1). Expected: ov_sticky=1 after the edge.
- Reset mid-operation: assert rst while in EXEC, and separately while in RESP. Expected: all outputs immediately 0 and state IDLE. No response is issued after release, and the next request completes normally with the PRIO_INIT ordering.

Source files
------------

// File: rtl/sr_alu_arb.sv
// Two-requester round-robin arbiter sharing one sr_alu, with registered response
// and a sticky saturation flag in the style of vxsat.

`ifndef ALU_ADD
`define ALU_ADD    3'b000
`define ALU_OR     3'b001
`define ALU_SRL    3'b010
`define ALU_SLTU   3'b011
`define ALU_SUB    3'b100
`define ALU_KSLL8  3'b101
`define ALU_KSLLI8 3'b110
`endif

module sr_alu (
  input  logic [31:0] srca_i,
  input  logic [31:0] srcb_i,
  input  logic [2:0]  oper_i,
  output logic        zero_o,
  output logic [31:0] result_o,
  output logic        ov_o
);

  // Signed byte shifted left by sh, clamped to [-128,127]; bit 8 flags a clamp.
  function automatic logic [8:0] ksll_sat(input logic signed [7:0] val,
                                          input logic [2:0] sh);
    logic signed [15:0] wide;
    wide = {{8{val[7]}}, val};
    wide = wide <<< sh;
    if (wide > 16'sd127)
      return {1'b1, 8'h7f};
    else if (wide < -16'sd128)
      return {1'b1, 8'h80};
    else
      return {1'b0, wide[7:0]};
  endfunction

  logic [31:0] ksll_res;
  logic        ksll_ov;
  logic [8:0]  lane;

  // KSLLI8 receives its immediate on srcB, so both forms share the lane logic.
  always_comb begin
    ksll_res = '0;
    ksll_ov  = 1'b0;
    lane     = '0;
    for (int i = 0; i < 4; i++) begin
      lane = ksll_sat($signed(srca_i[8*i +: 8]), srcb_i[2:0]);
      ksll_res[8*i +: 8] = lane[7:0];
      ksll_ov = ksll_ov | lane[8];
    end
  end

  always_comb begin
    case (oper_i)
      `ALU_OR:     result_o = srca_i | srcb_i;
      `ALU_SRL:    result_o = srca_i >> srcb_i[4:0];
      `ALU_SLTU:   result_o = {31'b0, srca_i < srcb_i};
      `ALU_SUB:    result_o = srca_i - srcb_i;
      `ALU_KSLL8:  result_o = ksll_res;
      `ALU_KSLLI8: result_o = ksll_res;
      default:     result_o = srca_i + srcb_i;
    endcase
  end

  // ov reflects the lane clamp regardless of opcode; the consumer must mask it.
  assign ov_o   = ksll_ov;
  assign zero_o = (result_o == 32'b0);

endmodule

module sr_alu_arb #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_srca_i,
  input  logic [31:0] req0_srcb_i,
  input  logic [2:0]  req0_oper_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_srca_i,
  input  logic [31:0] req1_srcb_i,
  input  logic [2:0]  req1_oper_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_ov_o,
  output logic        ov_sticky_o,
  input  logic        ov_clr_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        ov_q, ov_d;
  logic        sticky_q, sticky_d;
  logic [31:0] srca_q, srcb_q;
  logic [2:0]  oper_q;

  logic        grant, idle_ok, accept;
  logic [31:0] alu_result;
  logic        alu_zero, alu_ov, ov_masked;

  assign grant   = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
  assign idle_ok = (state_q == IDLE) && !rst;
  assign req0_ready_o = idle_ok && !grant && req0_valid_i;
  assign req1_ready_o = idle_ok &&  grant && req1_valid_i;
  assign accept = req0_ready_o || req1_ready_o;

  sr_alu u_alu (
    .srca_i   (srca_q),
    .srcb_i   (srcb_q),
    .oper_i   (oper_q),
    .zero_o   (alu_zero),
    .result_o (alu_result),
    .ov_o     (alu_ov)
  );

  assign ov_masked = alu_ov && ((oper_q == `ALU_KSLL8) || (oper_q == `ALU_KSLLI8));

  // Operand capture happens only on the handshake edge; these are never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      srca_q <= grant ? req1_srca_i : req0_srca_i;
      srcb_q <= grant ? req1_srcb_i : req0_srcb_i;
      oper_q <= grant ? req1_oper_i : req0_oper_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    result_d = result_q;
    zero_d   = zero_q;
    ov_d     = ov_q;
    sticky_d = sticky_q && !ov_clr_i;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          prio_d  = !grant;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        ov_d     = ov_masked;
        if (ov_masked) sticky_d = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_q ? rsp1_ready_i : rsp0_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= PRIO_INIT;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ov_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ov_q     <= ov_d;
      sticky_q <= sticky_d;
    end
  end

  assign rsp0_valid_o = (state_q == RESP) && !owner_q;
  assign rsp1_valid_o = (state_q == RESP) &&  owner_q;
  assign rsp_result_o = result_q;
  assign rsp_zero_o   = zero_q;
  assign rsp_ov_o     = ov_q;
  assign ov_sticky_o  = sticky_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_sr_alu_arb.sv
// Scoreboard bench for sr_alu_arb: expected responses are queued at accept time
// and compared when the owning response channel presents them.

module tb_sr_alu_arb;

  localparam logic [2:0] OP_ADD = 3'd0, OP_OR = 3'd1, OP_SRL = 3'd2, OP_SLTU = 3'd3,
                         OP_SUB = 3'd4, OP_KSLL8 = 3'd5, OP_KSLLI8 = 3'd6, OP_NONE = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_srca = '0, req0_srcb = '0, req1_srca = '0, req1_srcb = '0;
  logic [2:0]  req0_oper = '0, req1_oper = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_ov, ov_sticky, busy;
  logic        ov_clr = 1'b0;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        ov;
    logic        st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic prio_m   = 1'b0;
  logic sticky_m = 1'b0;

  always #5 clk = ~clk;

  sr_alu_arb #(.PRIO_INIT(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_srca_i  (req0_srca),
    .req0_srcb_i  (req0_srcb),
    .req0_oper_i  (req0_oper),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_srca_i  (req1_srca),
    .req1_srcb_i  (req1_srcb),
    .req1_oper_i  (req1_oper),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_ready_i (rsp0_ready),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_ready_i (rsp1_ready),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .rsp_ov_o     (rsp_ov),
    .ov_sticky_o  (ov_sticky),
    .ov_clr_i     (ov_clr),
    .busy_o       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
    exp_t e;
    logic [31:0] ks;
    logic        sat;
    logic signed [7:0] by;
    int v;
    int sh;
    ks  = '0;
    sat = 1'b0;
    sh  = int'(b[2:0]);
    for (int i = 0; i < 4; i++) begin
      by = a[8*i +: 8];
      v  = int'(by) * (1 << sh);
      if (v > 127) begin
        ks[8*i +: 8] = 8'h7f; sat = 1'b1;
      end else if (v < -128) begin
        ks[8*i +: 8] = 8'h80; sat = 1'b1;
      end else begin
        ks[8*i +: 8] = v[7:0];
      end
    end
    case (op)
      OP_OR:     e.r = a | b;
      OP_SRL:    e.r = a >> b[4:0];
      OP_SLTU:   e.r = (a < b) ? 32'd1 : 32'd0;
      OP_SUB:    e.r = a - b;
      OP_KSLL8,
      OP_KSLLI8: e.r = ks;
      default:   e.r = a + b;
    endcase
    e.ov = (op == OP_KSLL8 || op == OP_KSLLI8) ? sat : 1'b0;
    e.z  = (e.r == 32'd0);
    e.st = 1'b0;
    return e;
  endfunction

  task automatic drive(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    if (n == 0) begin
      req0_srca = a; req0_srcb = b; req0_oper = op; req0_valid = 1'b1;
    end else begin
      req1_srca = a; req1_srcb = b; req1_oper = op; req1_valid = 1'b1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the EXEC cycle.
  task automatic send(input int n, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input bit clr_exec);
    bit   got;
    exp_t e;
    got = 1'b0;
    drive(n, a, b, op);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("req_timeout", 32'd0, 32'd1);
      if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    chk("req_other_rdy", (n == 0) ? req1_ready : req0_ready, 32'd0);
    e = model(a, b, op);
    if (e.ov) sticky_m = 1'b1;
    else if (clr_exec) sticky_m = 1'b0;
    e.st = sticky_m;
    sb.push_back(e);
    prio_m = (n == 0);
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (clr_exec) ov_clr = 1'b1;
  endtask

  task automatic recv(input int n, input int stall);
    bit   got;
    int   k_found;
    exp_t e;
    got = 1'b0;
    k_found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) begin
        got = 1'b1; k_found = k;
        break;
      end
    end
    ov_clr = 1'b0;
    if (!got) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      @(posedge clk); #1;
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("latency", k_found, 32'd1);
    chk("rsp_owner", (n == 0) ? rsp0_valid : rsp1_valid, 32'd1);
    chk("rsp_other", (n == 0) ? rsp1_valid : rsp0_valid, 32'd0);
    chk("rsp_result", rsp_result, e.r);
    chk("rsp_zero", rsp_zero, e.z);
    chk("rsp_ov", rsp_ov, e.ov);
    chk("ov_sticky", ov_sticky, e.st);
    if (stall > 0) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      if (n == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("bp_valid", (n == 0) ? rsp0_valid : rsp1_valid, 32'd1);
      chk("bp_result", rsp_result, e.r);
      chk("bp_zero", rsp_zero, e.z);
      chk("bp_req_rdy", {req1_ready, req0_ready}, 32'd0);
      chk("bp_busy", busy, 32'd1);
    end
    if (stall > 0) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    end
    if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk("rsp_done", {rsp1_valid, rsp0_valid}, 32'd0);
    chk("idle_busy", busy, 32'd0);
  endtask

  task automatic pair(input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                      input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1);
    drive(0, a0, b0, op0);
    drive(1, a1, b1, op1);
    if (prio_m == 1'b0) begin
      send(0, a0, b0, op0, 1'b0); recv(0, 0);
      send(1, a1, b1, op1, 1'b0); recv(1, 0);
    end else begin
      send(1, a1, b1, op1, 1'b0); recv(1, 0);
      send(0, a0, b0, op0, 1'b0); recv(0, 0);
    end
  endtask

  task automatic clear_sticky();
    ov_clr = 1'b1;
    @(posedge clk); #1;
    ov_clr = 1'b0;
    sticky_m = 1'b0;
    chk("sticky_clr", ov_sticky, 32'd0);
  endtask

  task automatic rst_mid(input int depth);
    send(0, 32'd10, 32'd20, OP_ADD, 1'b0);
    void'(sb.pop_back());
    if (depth == 2) begin
      @(posedge clk); #1;
      chk("pre_rst_resp", rsp0_valid, 32'd1);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_rsp_vld", {rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_req_rdy", {req1_ready, req0_ready}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_flags", {rsp_zero, rsp_ov, ov_sticky}, 32'd0);
    chk("rst_busy", busy, 32'd0);
    sticky_m = 1'b0;
    prio_m   = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {rsp1_valid, rsp0_valid, busy}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #3;
    chk("reset_rsp_vld", {rsp1_valid, rsp0_valid}, 32'd0);
    chk("reset_req_rdy", {req1_ready, req0_ready}, 32'd0);
    chk("reset_result", rsp_result, 32'd0);
    chk("reset_flags", {rsp_zero, rsp_ov, ov_sticky}, 32'd0);
    chk("reset_busy", busy, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // contention after reset, then a third simultaneous pair
    pair(32'd1, 32'd1, OP_ADD, 32'd9, 32'd4, OP_SUB);
    pair(32'hF0, 32'h0F, OP_OR, 32'd3, 32'd8, OP_SLTU);

    send(0, 32'd5, 32'd7, OP_ADD, 1'b0);
    recv(0, 0);

    // saturation, ov masking on a non-saturating opcode, then clear
    send(1, 32'h4001807F, 32'd1, OP_KSLL8, 1'b0);
    recv(1, 0);
    send(1, 32'h40404040, 32'd1, OP_ADD, 1'b0);
    recv(1, 0);
    clear_sticky();

    // backpressure
    send(0, 32'd3, 32'd3, OP_SUB, 1'b0);
    recv(0, 5);

    // set and clear on the same capture edge
    send(0, 32'h0000007F, 32'd1, OP_KSLL8, 1'b1);
    recv(0, 0);
    clear_sticky();

    for (int i = 0; i < 12; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom_range(0, 7));
      if (i == 3) rop = OP_NONE;
      if (i == 5) rop = OP_KSLLI8;
      if (i == 7) rop = OP_SRL;
      send(i % 2, ra, rb, rop, 1'b0);
      recv(i % 2, 0);
    end

    rst_mid(1);
    pair(32'd2, 32'd2, OP_ADD, 32'd100, 32'd1, OP_SUB);
    rst_mid(2);
    pair(32'h80808080, 32'd1, OP_KSLLI8, 32'h0, 32'h0, OP_ADD);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
